// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register bank: command-byte layout, op codes
// and FSM state encoding.
package spi_reg_pkg;

  localparam int CMD_RW      = 7;
  localparam int CMD_OP_HI   = 6;
  localparam int CMD_OP_LO   = 5;
  localparam int CMD_ADDR_HI = 4;
  localparam int CMD_ADDR_LO = 0;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_SET = 2'b01,
    OP_CLR = 2'b10,
    OP_TGL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/spi_reg_bank_sync_if.sv
// SPI pin bundle; the host side is the master, the register bank the slave.
interface spi_reg_bank_sync_if;
  logic spi_clk;
  logic spi_cs;
  logic spi_sdi;
  logic spi_sdo;

  modport master (output spi_clk, output spi_cs, output spi_sdi, input spi_sdo);
  modport slave  (input spi_clk, input spi_cs, input spi_sdi, output spi_sdo);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser followed by an edge-detect stage; rise/fall are
// registered one-cycle pulses, three clk cycles after the pin moves.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/spi_reg_bank_sync.sv
// SPI-slave register bank with write/set/clear/toggle ops, fully in the clk
// domain. States: IDLE | waiting for cs fall; CMD | shifting the command byte;
// DATA | shifting data bits, tx drives sdo.
module spi_reg_bank_sync
  import spi_reg_pkg::*;
#(
  parameter int NREG   = 8,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 5,
  parameter logic [NREG*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_reg_bank_sync_if.slave     bus,
  output logic [NREG*DATA_W-1:0] regs_o,
  output logic [NREG-1:0]        wr_stb
);

  localparam int FL    = 8 + DATA_W;
  localparam int CNT_W = $clog2(FL + 2);
  localparam logic [CNT_W-1:0]  CNT_FL  = CNT_W'(FL);
  localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(FL + 1);
  localparam logic [ADDR_W:0]   NREG_L  = (ADDR_W + 1)'(NREG);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic sdi_s1, sdi_s2, sdi_q;

  spi_sync_edge u_sclk (.clk(clk), .rst(rst), .din(bus.spi_clk), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_cs   (.clk(clk), .rst(rst), .din(bus.spi_cs),  .rise(cs_rise),   .fall(cs_fall));

  // sdi is delayed to the same depth as the edge pulses so it is sampled
  // at the instant the sclk rise was observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdi_s1 <= 1'b0;
      sdi_s2 <= 1'b0;
      sdi_q  <= 1'b0;
    end else begin
      sdi_s1 <= bus.spi_sdi;
      sdi_s2 <= sdi_s1;
      sdi_q  <= sdi_s2;
    end
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          cmd_q;
  logic [7:0]          cmd_nxt;
  logic [DATA_W-1:0]   rx_q, tx_q;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   rd_val, cur_val, alu_res;
  logic [ADDR_W-1:0]   rd_addr, wr_addr;
  logic                rd_ok, wr_ok;
  logic                start_f, shift_rx, load_tx, shift_tx, commit;

  assign cmd_nxt = {cmd_q[6:0], sdi_q};
  assign rd_addr = cmd_nxt[CMD_ADDR_HI:CMD_ADDR_LO];
  assign wr_addr = cmd_q[CMD_ADDR_HI:CMD_ADDR_LO];
  assign rd_ok   = ({1'b0, rd_addr} < NREG_L);
  assign wr_ok   = ({1'b0, wr_addr} < NREG_L);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cs_fall) state_d = CMD;
        CMD:     if (sclk_rise && cnt_q == CNT_W'(7)) state_d = DATA;
        DATA:    state_d = DATA;
        default: state_d = IDLE;
      endcase
    end
  end

  // A cs rise in the same cycle as an sclk edge suppresses the edge.
  always_comb begin
    start_f  = 1'b0;
    shift_rx = 1'b0;
    load_tx  = 1'b0;
    shift_tx = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: start_f = cs_fall & ~cs_rise;
      CMD: begin
        shift_rx = sclk_rise & ~cs_rise;
        load_tx  = sclk_rise & ~cs_rise & (cnt_q == CNT_W'(7));
      end
      DATA: begin
        shift_rx = sclk_rise & ~cs_rise;
        shift_tx = sclk_fall & ~cs_rise;
        commit   = cs_rise & (cnt_q == CNT_FL) & ~cmd_q[CMD_RW] & wr_ok;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_val  = '0;
    cur_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_val  = regs_q[i];
      if (wr_addr == ADDR_W'(i)) cur_val = regs_q[i];
    end
    if (!(cmd_nxt[CMD_RW] && rd_ok)) rd_val = '0;
  end

  always_comb begin
    case (op_e'(cmd_q[CMD_OP_HI:CMD_OP_LO]))
      OP_WR:   alu_res = rx_q;
      OP_SET:  alu_res = cur_val | rx_q;
      OP_CLR:  alu_res = cur_val & ~rx_q;
      OP_TGL:  alu_res = cur_val ^ rx_q;
      default: alu_res = rx_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      cmd_q <= '0;
      rx_q  <= '0;
      tx_q  <= '0;
    end else if (start_f) begin
      cnt_q <= '0;
      cmd_q <= '0;
      rx_q  <= '0;
      tx_q  <= '0;
    end else if (cs_rise) begin
      tx_q  <= '0;
    end else begin
      if (shift_rx) begin
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
        if (state_q == CMD) cmd_q <= cmd_nxt;
        else                rx_q  <= {rx_q[DATA_W-2:0], sdi_q};
      end
      if (load_tx)       tx_q <= rd_val;
      else if (shift_tx) tx_q <= {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      wr_stb <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        wr_stb[i] <= commit && (wr_addr == ADDR_W'(i));
        if (commit && (wr_addr == ADDR_W'(i))) regs_q[i] <= alu_res;
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign bus.spi_sdo = (state_q != IDLE) & tx_q[DATA_W-1];

endmodule

// File: doc/spi_reg_bank_sync.md
# spi_reg_bank_sync

Parametrised SPI-slave register bank, the successor to the fixed 24-bit bank. All logic runs in the single system clock domain: the SPI pins are oversampled through synchronisers, so the block needs no SPI-clocked flops. It provides NREG registers of DATA_W bits with full read-back, plus write, bit-set, bit-clear and toggle operations. A one-cycle write strobe per register tells downstream logic (LED, SPI mux, 4094 drivers) when to act.

## Interface
- NREG, 8: number of registers, 1..32.
- DATA_W, 24: register width, 8..32.
- ADDR_W, 5: address field width, fixed at 5.
- RESET_VAL, 0: flattened NREG*DATA_W reset values; register i uses bits [i*DATA_W +: DATA_W].
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- spi_clk  in  1  SPI SCLK, asynchronous, mode 0.
- spi_cs  in  1  chip select, active-low, asynchronous.
- spi_sdi  in  1  MOSI, asynchronous.
- spi_sdo  out  1  MISO, registered in the clk domain.
- regs_o  out  NREG*DATA_W  current register contents, flattened.
- wr_stb  out  NREG  one-cycle pulse on the cycle a register's contents are committed.

## Operation
- Frame format, MSB first: command byte, then DATA_W data bits. Frame length is FL = 8 + DATA_W.
- Command byte: cmd[7] = 1 for read, 0 for write. cmd[6:5] = op: 00 write, 01 set (reg |= d), 10 clear (reg &= ~d), 11 toggle (reg ^= d). cmd[4:0] = address.
- Inputs are sampled on detected spi_clk rising edges. spi_sdo changes on detected falling edges.
- FSM states:
  - IDLE → CMD on a detected spi_cs fall: bit count and shift registers cleared, spi_sdo = 0.
  - CMD → DATA after the 8th rising edge. In the same cycle, the tx shift register is loaded: the addressed register for a read, 0 for a write or an address ≥ NREG. spi_sdo immediately presents the loaded MSB.
  - DATA: each falling edge shifts tx left with zero fill. Each rising edge shifts sdi into rx. The bit counter saturates at FL+1.
  - Any state → IDLE on a detected spi_cs rise.
- Commit, on the spi_cs rise event, only when all of the following hold: bit count == FL exactly, cmd[7] = 0, and address < NREG. The addressed register receives the op result; its wr_stb bit pulses. All other cases are discarded silently: short frames, long frames, reads, and out-of-range addresses.
- Reads never modify registers and never strobe.
- A spi_cs rise and a spi_clk edge detected in the same cycle: the cs event wins and the clock edge is ignored.
- rst, at any time including mid-frame: FSM to IDLE, counters and shift registers to 0, spi_sdo = 0, regs_o = RESET_VAL, wr_stb = 0. The frame in progress is discarded.
- spi_sdo = 0 whenever the FSM is in IDLE.

## Timing
- Each asynchronous input passes through a 2-FF synchroniser and then an edge-detect register. A pin transition is seen as an event 3 clk cycles later.
- regs_o and wr_stb update 1 cycle after the cs-rise event, i.e. 4 clk cycles after the spi_cs pin rises. wr_stb is exactly 1 cycle wide.
- spi_sdo updates 1 cycle after a falling-edge event, and 1 cycle after the 8th rising-edge event for the first data bit.
- Host constraints: SCLK high time ≥ 4 clk periods and low time ≥ 4 clk periods; spi_cs high time between frames ≥ 4 clk periods. Behaviour outside these constraints is undefined. The block does not need to detect violations.
- Data MSB setup: the first data bit is valid on spi_sdo at most 5 clk cycles after the 8th SCLK rising pin edge. This is within the low half-period plus the high half-period preceding the next sample.

## Structure
- Package spi_reg_pkg holds:
  - command bit positions: CMD_RW = 7, CMD_OP = 6:5, CMD_ADDR = 4:0;
  - op encodings: OP_WR, OP_SET, OP_CLR, OP_TGL;
  - FSM state encoding: IDLE, CMD, DATA.
- Sub-module spi_sync_edge: 2-FF synchroniser plus rise/fall pulse outputs, instantiated for spi_clk and spi_cs. spi_sdi uses only the synchroniser path.
- Top level contains the FSM, the counter, the rx/tx shifters, the register array and the op ALU.

## Test plan
- Reset with RESET_VAL[reg 7] = 24'h000015 → regs_o reg 7 = 0x000015, wr_stb = 0, spi_sdo = 0.
- Write frame 0x07 then 0xABCDEF, followed by a read frame 0x87 → reg 7 = 0xABCDEF; wr_stb[7] pulses once, 4 clk cycles after the cs pin rises; the read returns 0xABCDEF on spi_sdo.
- With reg 2 = 0x00F00F: set 0x22 with 0x000F00 → 0x00FF0F. Then clear 0x42 with 0x0000FF → 0x00FF00. Then toggle 0x62 with 0xFFFFFF → 0xFF00FF.
- A 31-bit write frame and a 33-bit write frame to reg 1 → reg 1 unchanged and no wr_stb.
- Write to address 31 with NREG = 8 → no change and no strobe. A read of address 31 returns 0x000000.
- rst asserted during the 20th bit of a write frame → registers return to RESET_VAL and no strobe occurs. The next complete frame executes normally.
